univ_reg: RTL and testbench
===========================

// Module: univ_reg
// PURPOSE
//   Parametrised universal register: successor to the fixed 4-bit switch-loaded register.
//   WIDTH-bit state with eight modes: hold, parallel load, shift, rotate and up/down count.
//   Registered carry flag; combinational zero flag.
//   Sits between switch/bus inputs and the datapath/LED outputs.
// PARAMETERS
//   WIDTH      4    register width in bits (>=2)
//   RESET_VAL  0    value loaded into out on reset (WIDTH bits)
// PORTS
//   clock     in   1      single clock, rising-edge
//   reset     in   1      asynchronous, active-high reset
//   enabling  in   1      1 = execute mode this edge; 0 = hold out and carry
//   mode      in   3      operation select (encodings below)
//   din       in   WIDTH  parallel load data
//   ser_in    in   1      serial fill bit for shifts
//   out       out  WIDTH  register contents
//   carry     out  1      registered: bit shifted/rotated out, or count overflow/underflow
//   zero      out  1      combinational, (out == 0)
// BEHAVIOUR
//   - Reset (async, active-high): out <= RESET_VAL, carry <= 0 immediately, no clock needed.
//     Reset mid-operation aborts the current mode; first op after release uses reset state.
//   - All state updates on rising clock edge when reset=0 and enabling=1.
//     Latency 1 cycle: result visible on out right after the edge.
//   - enabling=0: out and carry hold regardless of mode/din/ser_in.
//   - Modes (out=q, W=WIDTH):
//       000 HOLD  q<=q;                          carry holds
//       001 LOAD  q<=din;                        carry<=0
//       010 SHL   q<={q[W-2:0],ser_in};          carry<=q[W-1]
//       011 SHR   q<={ser_in,q[W-1:1]};          carry<=q[0]
//       100 ROL   q<={q[W-2:0],q[W-1]};          carry<=q[W-1]
//       101 ROR   q<={q[0],q[W-1:1]};            carry<=q[0]
//       110 INC   q<=q+1 mod 2^W;  carry<=1 iff q was all-ones, else 0
//       111 DEC   q<=q-1 mod 2^W;  carry<=1 iff q was zero, else 0
//   - Arithmetic in W+1 bits; MSB of the sum/difference is the carry source.
//   - zero tracks out with no cycle delay, including during reset.
//   - No illegal modes; all 3-bit values defined.
// CONFIGURATION
//   SAT_EN defined: INC at all-ones keeps q=all-ones; DEC at zero keeps q=0.
//     carry is still set to 1 on that edge (saturation indicator).
//   SAT_EN undefined: INC/DEC wrap modulo 2^W as above.
//   No other behaviour differs.
// STRUCTURE
//   - Shared package univ_reg_pkg: 3-bit mode encodings MODE_HOLD .. MODE_DEC.
//     Include file with localparams, shared by RTL and bench.
//   - One sub-module, univ_reg_next: purely combinational.
//     Inputs q, mode, din, ser_in; outputs next q and next carry.
//     Holds the SAT_EN logic.
//   - Top holds only the async-reset flops and the enabling gate.
// TESTING (WIDTH=4, RESET_VAL=0 unless noted)
//   1. Assert reset mid-cycle with out=4'hA:
//      -> out=0, carry=0, zero=1 before the next edge.
//      RESET_VAL=4'h5 -> out=5.
//   2. enabling=1, LOAD din=4'hF -> out=F, carry=0.
//      Then enabling=0 with LOAD din=4'h3 for 3 edges -> out stays F.
//   3. From 4'b1001: SHL ser_in=0 -> 0010, carry=1.
//      Then SHR ser_in=1 -> 1001, carry=0.
//      ROL from 1001 -> 0011, carry=1.
//   4. INC from F, no SAT_EN -> out=0, carry=1, zero=1.
//      Then DEC -> out=F, carry=1.
//   5. SAT_EN build: INC from F -> out=F, carry=1.
//      DEC from 0 -> out=0, carry=1.
//      INC from 7 -> 8, carry=0.
//   6. Random mode/din/ser_in/enabling for 10k cycles with random async resets:
//      out/carry match the reference model each edge.
//      zero == (out==0) at all times.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared mode encodings for the universal register.
// Imported by the register, its next-state logic and the bench.
package univ_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_reg_if.sv
// Control/data bundle of the universal register.
// master: enabling, mode, din, ser_in out; out, carry, zero in.
interface univ_reg_if #(
  parameter int WIDTH = 4
);

  logic             enabling;
  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             ser_in;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  modport master (
    output enabling, mode, din, ser_in,
    input  out, carry, zero
  );

  modport slave (
    input  enabling, mode, din, ser_in,
    output out, carry, zero
  );

endinterface

// File: rtl/univ_reg_next.sv
// Next-state logic: q, carry, mode, din, ser_in -> q_nxt, c_nxt.
// SAT_EN: INC/DEC saturate instead of wrapping.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             c,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_nxt,
  output logic             c_nxt
);

  logic [WIDTH:0] one;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  // Top bit of the W+1 result is the overflow / borrow.
  assign one = {{WIDTH{1'b0}}, 1'b1};
  assign sum = {1'b0, q} + one;
  assign dif = {1'b0, q} - one;

  always_comb begin
    q_nxt = q;
    c_nxt = c;
    unique case (mode)
      MODE_HOLD: begin
        q_nxt = q;
        c_nxt = c;
      end
      MODE_LOAD: begin
        q_nxt = din;
        c_nxt = 1'b0;
      end
      MODE_SHL: begin
        q_nxt = {q[WIDTH-2:0], ser_in};
        c_nxt = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt = {ser_in, q[WIDTH-1:1]};
        c_nxt = q[0];
      end
      MODE_ROL: begin
        q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        c_nxt = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt = {q[0], q[WIDTH-1:1]};
        c_nxt = q[0];
      end
      MODE_INC: begin
        c_nxt = sum[WIDTH];
`ifdef SAT_EN
        q_nxt = sum[WIDTH] ? q : sum[WIDTH-1:0];
`else
        q_nxt = sum[WIDTH-1:0];
`endif
      end
      MODE_DEC: begin
        c_nxt = dif[WIDTH];
`ifdef SAT_EN
        q_nxt = dif[WIDTH] ? q : dif[WIDTH-1:0];
`else
        q_nxt = dif[WIDTH-1:0];
`endif
      end
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// Universal register: hold/load/shift/rotate/count, carry + zero flags.
// Ports: clock, reset (async high), bus (slave). Option macro: SAT_EN.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic      clock,
  input logic      reset,
  univ_reg_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic             c;
  logic [WIDTH-1:0] q_nxt;
  logic             c_nxt;

  univ_reg_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q     (q),
    .c     (c),
    .mode  (bus.mode),
    .din   (bus.din),
    .ser_in(bus.ser_in),
    .q_nxt (q_nxt),
    .c_nxt (c_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
      c <= 1'b0;
    end else if (bus.enabling) begin
      q <= q_nxt;
      c <= c_nxt;
    end
  end

  assign bus.out   = q;
  assign bus.carry = c;
  assign bus.zero  = (q == '0);

endmodule

// File: tb/tb_univ_reg.sv
// Directed + randomised bench for univ_reg (WIDTH=4).
// Honours SAT_EN when the build defines it.
module tb_univ_reg;
  import univ_reg_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  univ_reg_if #(.WIDTH(4)) bus ();
  univ_reg_if #(.WIDTH(4)) bus5 ();

  univ_reg #(
    .WIDTH(4),
    .RESET_VAL(4'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  univ_reg #(
    .WIDTH(4),
    .RESET_VAL(4'h5)
  ) dut5 (
    .clock(clock),
    .reset(reset),
    .bus  (bus5.slave)
  );

  assign bus5.enabling = bus.enabling;
  assign bus5.mode     = bus.mode;
  assign bus5.din      = bus.din;
  assign bus5.ser_in   = bus.ser_in;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] m,
                       input logic [3:0] d, input logic s);
    bus.enabling = en;
    bus.mode     = m;
    bus.din      = d;
    bus.ser_in   = s;
  endtask

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [3:0] q,
                        input logic c);
    chk({tag, ".out"}, {4'h0, bus.out}, {4'h0, q});
    chk({tag, ".carry"}, {7'h0, bus.carry}, {7'h0, c});
    chk({tag, ".zero"}, {7'h0, bus.zero}, {7'h0, q == 4'h0});
  endtask

  // Reference written with integer arithmetic; returns {carry, q}.
  function automatic logic [4:0] model(input int q, input int c,
                                       input int m, input int d,
                                       input int s);
    int nq;
    int nc;
    nq = q;
    nc = c;
    case (m)
      1: begin nq = d; nc = 0; end
      2: begin nq = (q * 2 + s) % 16; nc = q / 8; end
      3: begin nq = s * 8 + q / 2; nc = q % 2; end
      4: begin nq = (q * 2) % 16 + q / 8; nc = q / 8; end
      5: begin nq = (q % 2) * 8 + q / 2; nc = q % 2; end
      6: begin
        if (q == 15) begin
`ifdef SAT_EN
          nq = 15;
`else
          nq = 0;
`endif
          nc = 1;
        end else begin
          nq = q + 1;
          nc = 0;
        end
      end
      7: begin
        if (q == 0) begin
`ifdef SAT_EN
          nq = 0;
`else
          nq = 15;
`endif
          nc = 1;
        end else begin
          nq = q - 1;
          nc = 0;
        end
      end
      default: ;
    endcase
    return {nc[0], nq[3:0]};
  endfunction

  logic [3:0] mq;
  logic       mc;
  logic [4:0] r;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, MODE_HOLD, 4'h0, 1'b0);
    #12;
    reset = 1'b0;
    #1;
    chk_st("por", 4'h0, 1'b0);
    chk("por5.out", {4'h0, bus5.out}, 8'h05);

    // Build out=A with carry=1, then reset mid-cycle.
    drive(1'b1, MODE_LOAD, 4'h5, 1'b0);
    edge1();
    drive(1'b1, MODE_SHR, 4'h0, 1'b1);
    edge1();
    chk_st("shr_a", 4'hA, 1'b1);
    drive(1'b0, MODE_HOLD, 4'h0, 1'b0);
    reset = 1'b1;
    #1;
    chk_st("async_rst", 4'h0, 1'b0);
    chk("async_rst5.out", {4'h0, bus5.out}, 8'h05);
    #1;
    reset = 1'b0;

    drive(1'b1, MODE_LOAD, 4'hF, 1'b0);
    edge1();
    chk_st("load_f", 4'hF, 1'b0);
    drive(1'b0, MODE_LOAD, 4'h3, 1'b0);
    edge1();
    edge1();
    edge1();
    chk_st("dis_hold", 4'hF, 1'b0);

    drive(1'b1, MODE_LOAD, 4'h9, 1'b0);
    edge1();
    drive(1'b1, MODE_SHL, 4'h0, 1'b0);
    edge1();
    chk_st("shl", 4'h2, 1'b1);
    drive(1'b1, MODE_SHR, 4'h0, 1'b1);
    edge1();
    chk_st("shr", 4'h9, 1'b0);
    drive(1'b1, MODE_ROL, 4'h0, 1'b0);
    edge1();
    chk_st("rol", 4'h3, 1'b1);
    drive(1'b1, MODE_ROR, 4'h0, 1'b0);
    edge1();
    chk_st("ror", 4'h9, 1'b1);
    drive(1'b1, MODE_HOLD, 4'h6, 1'b1);
    edge1();
    chk_st("hold", 4'h9, 1'b1);

    drive(1'b1, MODE_LOAD, 4'hF, 1'b0);
    edge1();
    drive(1'b1, MODE_INC, 4'h0, 1'b0);
    edge1();
`ifdef SAT_EN
    chk_st("inc_top", 4'hF, 1'b1);
`else
    chk_st("inc_top", 4'h0, 1'b1);
`endif
    drive(1'b1, MODE_LOAD, 4'h0, 1'b0);
    edge1();
    drive(1'b1, MODE_DEC, 4'h0, 1'b0);
    edge1();
`ifdef SAT_EN
    chk_st("dec_bot", 4'h0, 1'b1);
`else
    chk_st("dec_bot", 4'hF, 1'b1);
`endif
    drive(1'b1, MODE_LOAD, 4'h7, 1'b0);
    edge1();
    drive(1'b1, MODE_INC, 4'h0, 1'b0);
    edge1();
    chk_st("inc_7", 4'h8, 1'b0);
    drive(1'b1, MODE_DEC, 4'h0, 1'b0);
    edge1();
    chk_st("dec_8", 4'h7, 1'b0);

    mq = 4'h7;
    mc = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
        #1;
        mq = 4'h0;
        mc = 1'b0;
        chk_st("rnd_rst", mq, mc);
        reset = 1'b0;
      end
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if (bus.enabling) begin
        r = model(int'(mq), int'(mc), int'(bus.mode),
                  int'(bus.din), int'(bus.ser_in));
        mq = r[3:0];
        mc = r[4];
      end
      edge1();
      chk_st("rnd", mq, mc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
